// File: rtl/frame_stream_source.sv
// Raster-order frame RAM reader feeding a ready/valid pixel stream through a 2-entry buffer.
// Define FRAME_SOURCE_SIDEBAND_EN to add the y_sof/y_eol sideband outputs.
module frame_stream_source #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int W          = 8,
  parameter int ADDR_W     = $clog2(IMG_WIDTH*IMG_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [W-1:0]      mem_rd_data,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [W-1:0]      y_data
`ifdef FRAME_SOURCE_SIDEBAND_EN
  ,
  output logic              y_sof,
  output logic              y_eol
`endif
);

  localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
`ifdef FRAME_SOURCE_SIDEBAND_EN
  localparam int TW    = W + 2;
  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
`else
  localparam int TW    = W;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              inflight_q, inflight_d;
  logic [TW-1:0]     fifo_q [2];
  logic [TW-1:0]     fifo_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef FRAME_SOURCE_SIDEBAND_EN
  logic [COL_W-1:0]  col_q, col_d;
  logic [1:0]        tag_q, tag_d;
`endif

  logic       pop;
  logic       rd_en;
  logic [2:0] occ;

  always_comb begin
    pop   = (count_q != 2'd0) && y_ready;
    // Occupancy the buffer will have once the read in flight lands and this cycle's pop retires.
    occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_en = (state_q == S_RUN) && (occ < 3'd2);

    state_d     = state_q;
    addr_d      = addr_q;
    last_addr_d = last_addr_q;
    inflight_d  = rd_en;
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef FRAME_SOURCE_SIDEBAND_EN
    col_d = col_q;
    tag_d = tag_q;
`endif

    if (inflight_q) begin
`ifdef FRAME_SOURCE_SIDEBAND_EN
      fifo_d[wr_ptr_q] = {tag_q, mem_rd_data};
`else
      fifo_d[wr_ptr_q] = mem_rd_data;
`endif
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};

    if (rd_en) begin
      last_addr_d = addr_q;
`ifdef FRAME_SOURCE_SIDEBAND_EN
      tag_d = {addr_q == '0, col_q == COL_W'(IMG_WIDTH-1)};
      col_d = (col_q == COL_W'(IMG_WIDTH-1)) ? '0 : col_q + COL_W'(1);
`endif
    end

    case (state_q)
      S_IDLE: begin
        addr_d = '0;
`ifdef FRAME_SOURCE_SIDEBAND_EN
        col_d = '0;
`endif
        if (start) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (rd_en) begin
          if (addr_q == ADDR_W'(NPIX-1)) state_d = S_DRAIN;
          else                            addr_d  = addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (pop && count_q == 2'd1 && !inflight_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      last_addr_q <= '0;
      inflight_q  <= 1'b0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef FRAME_SOURCE_SIDEBAND_EN
      col_q       <= '0;
      tag_q       <= 2'b00;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      inflight_q  <= inflight_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef FRAME_SOURCE_SIDEBAND_EN
      col_q       <= col_d;
      tag_q       <= tag_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_rd_en = rd_en;
  assign mem_addr  = rd_en ? addr_q : last_addr_q;
  assign y_valid   = (count_q != 2'd0);
  assign y_data    = fifo_q[rd_ptr_q][W-1:0];
`ifdef FRAME_SOURCE_SIDEBAND_EN
  assign y_sof     = fifo_q[rd_ptr_q][W+1];
  assign y_eol     = fifo_q[rd_ptr_q][W];
`endif

endmodule
